// File: rtl/bus_slave_sram_if.sv
// CPU bus signal bundle between a bus owner and one slave slot.
// The master drives the request side; the slave returns rd_data and the rdy_ pulse.
interface bus_slave_sram_if;
    logic        cs_;
    logic        as_;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rdy_;

    modport master (
        output cs_, as_, rw, addr, wr_data,
        input  rd_data, rdy_
    );

    modport slave (
        input  cs_, as_, rw, addr, wr_data,
        output rd_data, rdy_
    );
endinterface

// File: rtl/bus_slave_sram.sv
// Single-word SRAM bus slave with WAIT_CYCLES wait states and a one-cycle active-low ready.
// Optional write protection of the lowest PROT_WORDS words: define BUS_SLAVE_SRAM_WPROT_EN.
module bus_slave_sram #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
`ifdef BUS_SLAVE_SRAM_WPROT_EN
    ,
    parameter int PROT_WORDS  = 16
`endif
) (
    input  logic            clk,
    input  logic            reset,
`ifdef BUS_SLAVE_SRAM_WPROT_EN
    output logic            prot_err,
`endif
    bus_slave_sram_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                rw_q, rw_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rd_data_q, rd_data_d;
    logic                rdy_n_q, rdy_n_d;
    logic                mem_we;
    logic                req;
    logic                accept;
    logic                ack_entry;
    logic                unused_addr_bits;

    logic [31:0]         mem [DEPTH];

`ifdef BUS_SLAVE_SRAM_WPROT_EN
    localparam logic [31:0] PROT_LIMIT = 32'(PROT_WORDS);
    logic                prot_err_q, prot_err_d;
    logic                prot_hit;
`endif

    assign req              = !bus.cs_ && !bus.as_;
    assign accept           = (state_q == S_IDLE) && req;
    assign ack_entry        = (state_d == S_ACK);
    assign unused_addr_bits = ^{bus.addr[31:ADDR_W+2], bus.addr[1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_ACK;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                // A master that drops as_ or cs_ mid-wait abandons the transfer.
                if (bus.as_ || bus.cs_) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // With zero wait states ACK is entered on the accepting edge, so the
    // ACK-entry actions below use the _d copies of the latched request.
    always_comb begin
        idx_d   = idx_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        if (accept) begin
            idx_d   = bus.addr[ADDR_W+1:2];
            rw_d    = bus.rw;
            wdata_d = bus.wr_data;
        end
    end

    always_comb begin
        rdy_n_d   = !ack_entry;
        rd_data_d = (ack_entry && rw_d) ? mem[idx_d] : 32'd0;
`ifdef BUS_SLAVE_SRAM_WPROT_EN
        prot_hit   = (32'(idx_d) < PROT_LIMIT);
        mem_we     = ack_entry && !rw_d && !prot_hit;
        prot_err_d = prot_err_q || (ack_entry && !rw_d && prot_hit);
`else
        mem_we     = ack_entry && !rw_d;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= 4'd0;
            idx_q      <= '0;
            rw_q       <= 1'b0;
            wdata_q    <= 32'd0;
            rd_data_q  <= 32'd0;
            rdy_n_q    <= 1'b1;
`ifdef BUS_SLAVE_SRAM_WPROT_EN
            prot_err_q <= 1'b0;
`endif
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            rw_q       <= rw_d;
            wdata_q    <= wdata_d;
            rd_data_q  <= rd_data_d;
            rdy_n_q    <= rdy_n_d;
`ifdef BUS_SLAVE_SRAM_WPROT_EN
            prot_err_q <= prot_err_d;
`endif
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_d] <= wdata_d;
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.rdy_    = rdy_n_q;
`ifdef BUS_SLAVE_SRAM_WPROT_EN
    assign prot_err    = prot_err_q;
`endif

endmodule

// File: tb/tb_bus_slave_sram.sv
// Bench for bus_slave_sram: three instances (WAIT_CYCLES 0/1/3) against an array-based model.
// Build with BUS_SLAVE_SRAM_WPROT_EN defined to also cover write protection.
module tb_bus_slave_sram;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;
    localparam int NI    = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        cs_v    [NI];
    logic        as_v    [NI];
    logic        rw_v    [NI];
    logic [31:0] addr_v  [NI];
    logic [31:0] wdata_v [NI];
    logic [31:0] rdata_v [NI];
    logic        rdy_v   [NI];

    int vectors     = 0;
    int miscompares = 0;

    bit [31:0] mdl [NI][DEPTH];
    bit        vld [NI][DEPTH];

    bus_slave_sram_if bus0 ();
    bus_slave_sram_if bus1 ();
    bus_slave_sram_if bus2 ();

    assign bus0.cs_ = cs_v[0]; assign bus0.as_ = as_v[0]; assign bus0.rw = rw_v[0];
    assign bus0.addr = addr_v[0]; assign bus0.wr_data = wdata_v[0];
    assign bus1.cs_ = cs_v[1]; assign bus1.as_ = as_v[1]; assign bus1.rw = rw_v[1];
    assign bus1.addr = addr_v[1]; assign bus1.wr_data = wdata_v[1];
    assign bus2.cs_ = cs_v[2]; assign bus2.as_ = as_v[2]; assign bus2.rw = rw_v[2];
    assign bus2.addr = addr_v[2]; assign bus2.wr_data = wdata_v[2];
    assign rdata_v[0] = bus0.rd_data; assign rdy_v[0] = bus0.rdy_;
    assign rdata_v[1] = bus1.rd_data; assign rdy_v[1] = bus1.rdy_;
    assign rdata_v[2] = bus2.rd_data; assign rdy_v[2] = bus2.rdy_;

`ifdef BUS_SLAVE_SRAM_WPROT_EN
    logic perr0, perr1, perr2;
    bit   perr_mdl [NI];
    bus_slave_sram #(.ADDR_W(AW), .WAIT_CYCLES(0), .PROT_WORDS(16)) dut0 (
        .clk(clk), .reset(reset), .prot_err(perr0), .bus(bus0.slave));
    bus_slave_sram #(.ADDR_W(AW), .WAIT_CYCLES(1), .PROT_WORDS(16)) dut1 (
        .clk(clk), .reset(reset), .prot_err(perr1), .bus(bus1.slave));
    bus_slave_sram #(.ADDR_W(AW), .WAIT_CYCLES(3), .PROT_WORDS(16)) dut2 (
        .clk(clk), .reset(reset), .prot_err(perr2), .bus(bus2.slave));
`else
    bus_slave_sram #(.ADDR_W(AW), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave));
    bus_slave_sram #(.ADDR_W(AW), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave));
    bus_slave_sram #(.ADDR_W(AW), .WAIT_CYCLES(3)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2.slave));
`endif

    function automatic int wc_of(int sel);
        return (sel == 0) ? 0 : (sel == 1) ? 1 : 3;
    endfunction

    function automatic int idx_of(logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic bit is_prot(int idx);
`ifdef BUS_SLAVE_SRAM_WPROT_EN
        return idx < 16;
`else
        return (idx < 0);
`endif
    endfunction

    task automatic model_write(int sel, logic [31:0] a, logic [31:0] d);
        int i;
        i = idx_of(a);
        if (!is_prot(i)) begin
            mdl[sel][i] = d;
            vld[sel][i] = 1'b1;
        end
`ifdef BUS_SLAVE_SRAM_WPROT_EN
        else perr_mdl[sel] = 1'b1;
`endif
    endtask

    // Drives one transaction, scrambling the request lines after acceptance.
    // lat = edges from the sampling edge to the first rdy_=0 sample, -1 if none.
    task automatic do_txn(input int sel, input bit rd, input logic [31:0] a,
                          input logic [31:0] d, input int abort_at, input bit keep,
                          output int lat, output logic [31:0] rdata,
                          output int stray, output bit held);
        cs_v[sel] = 1'b0; as_v[sel] = 1'b0; rw_v[sel] = rd;
        addr_v[sel] = a; wdata_v[sel] = d;
        lat = -1; rdata = '0; stray = 0; held = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            addr_v[sel] = $urandom; wdata_v[sel] = $urandom; rw_v[sel] = 1'($urandom);
            if (abort_at > 0 && c == abort_at) begin
                as_v[sel] = 1'b1; cs_v[sel] = 1'b1;
            end
            if (rdy_v[sel] === 1'b0) begin
                lat = c;
                rdata = rdata_v[sel];
                if (!keep) begin
                    as_v[sel] = 1'b1; cs_v[sel] = 1'b1;
                end
                @(posedge clk); #1;
                held = (rdy_v[sel] !== 1'b1) || (rdata_v[sel] !== 32'd0);
                break;
            end else if (rdata_v[sel] !== 32'd0) begin
                stray++;
            end
            if (abort_at > 0 && c >= abort_at + 6) break;
        end
        if (abort_at > 0 || lat < 0) begin
            as_v[sel] = 1'b1; cs_v[sel] = 1'b1;
        end
    endtask

    // Full transaction plus checks of latency, pulse width, idle data and read data.
    task automatic txn_check(string name, int sel, bit rd, logic [31:0] a,
                             logic [31:0] d, bit keep);
        int lat, stray; bit held; logic [31:0] rdata; int i;
        i = idx_of(a);
        do_txn(sel, rd, a, d, 0, keep, lat, rdata, stray, held);
        vectors++;
        if (lat !== wc_of(sel) + 1) begin
            miscompares++;
            $display("[TB] FAIL %s lat inst%0d: got %0d want %0d", name, sel, lat, wc_of(sel) + 1);
        end
        vectors++;
        if (held !== 1'b0 || stray !== 0) begin
            miscompares++;
            $display("[TB] FAIL %s pulse inst%0d: held=%0d stray=%0d want 0/0", name, sel, held, stray);
        end
        if (rd && vld[sel][i]) begin
            vectors++;
            if (rdata !== mdl[sel][i]) begin
                miscompares++;
                $display("[TB] FAIL %s rdata inst%0d: got %h want %h", name, sel, rdata, mdl[sel][i]);
            end
        end
        if (!rd && lat > 0) model_write(sel, a, d);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int s = 0; s < NI; s++) begin
            cs_v[s] = 1'b1; as_v[s] = 1'b1; rw_v[s] = 1'b1; addr_v[s] = '0; wdata_v[s] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < NI; s++) begin
            vectors++;
            if (rdy_v[s] !== 1'b1 || rdata_v[s] !== 32'd0) begin
                miscompares++;
                $display("[TB] FAIL reset inst%0d: rdy_=%b rd_data=%h want 1/0", s, rdy_v[s], rdata_v[s]);
            end
        end
`ifdef BUS_SLAVE_SRAM_WPROT_EN
        vectors++;
        if ({perr0, perr1, perr2} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset prot_err: got %b want 000", {perr0, perr1, perr2});
        end
`endif
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        txn_check("wr_deadbeef", 1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        txn_check("rd_deadbeef", 1, 1'b1, 32'h0000_0010, 32'h0, 1'b0);
    endtask

    task automatic test_latency_sweep();
        logic [31:0] a;
        for (int s = 0; s < NI; s++) begin
            a = {20'h0, 2'b01, 8'($urandom), 2'b00};
            txn_check("sweep_wr", s, 1'b0, a, $urandom, 1'b0);
            txn_check("sweep_rd", s, 1'b1, a, 32'h0, 1'b0);
            txn_check("seed_100", s, 1'b0, 32'h0000_0100, $urandom, 1'b0);
            txn_check("seed_200", s, 1'b0, 32'h0000_0200, $urandom, 1'b0);
        end
    endtask

    task automatic test_abort();
        int lat, stray; bit held; logic [31:0] rdata;
        for (int s = 1; s < NI; s++) begin
            do_txn(s, 1'b1, 32'h0000_0100, 32'h0, 1, 1'b0, lat, rdata, stray, held);
            vectors++;
            if (lat !== -1) begin
                miscompares++;
                $display("[TB] FAIL abort_read inst%0d: rdy_ seen at %0d want none", s, lat);
            end
            do_txn(s, 1'b0, 32'h0000_0100, 32'h1234_5678, 1, 1'b0, lat, rdata, stray, held);
            vectors++;
            if (lat !== -1) begin
                miscompares++;
                $display("[TB] FAIL abort_write inst%0d: rdy_ seen at %0d want none", s, lat);
            end
            txn_check("after_abort", s, 1'b1, 32'h0000_0100, 32'h0, 1'b0);
        end
    endtask

    task automatic test_cs_high();
        cs_v[1] = 1'b1; as_v[1] = 1'b0; rw_v[1] = 1'b0;
        addr_v[1] = 32'h0000_0100; wdata_v[1] = 32'hCAFE_F00D;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            rw_v[1] = 1'($urandom);
            vectors++;
            if (rdy_v[1] !== 1'b1 || rdata_v[1] !== 32'd0) begin
                miscompares++;
                $display("[TB] FAIL cs_high cyc%0d: rdy_=%b rd_data=%h want 1/0", c, rdy_v[1], rdata_v[1]);
            end
        end
        as_v[1] = 1'b1;
        @(posedge clk); #1;
        txn_check("cs_high_mem", 1, 1'b1, 32'h0000_0100, 32'h0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int s = 0; s < NI; s++) begin
            txn_check("b2b_wr_alias", s, 1'b0, 32'h0000_1000, 32'hA5A5_A5A5, 1'b1);
            txn_check("b2b_rd_alias", s, 1'b1, 32'h0000_0000, 32'h0, 1'b0);
            txn_check("b2b_wr", s, 1'b0, 32'h0000_0104, $urandom, 1'b1);
            txn_check("b2b_raw", s, 1'b1, 32'hFFFF_F107, 32'h0, 1'b0);
        end
    endtask

    task automatic test_reset_mid_wait();
        cs_v[2] = 1'b0; as_v[2] = 1'b0; rw_v[2] = 1'b0;
        addr_v[2] = 32'h0000_0200; wdata_v[2] = 32'h0BAD_0BAD;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        vectors++;
        if (rdy_v[2] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_wait immediate: rdy_=%b want 1", rdy_v[2]);
        end
        @(posedge clk); #1;
        vectors++;
        if (rdy_v[2] !== 1'b1 || rdata_v[2] !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_wait next: rdy_=%b rd_data=%h want 1/0", rdy_v[2], rdata_v[2]);
        end
        cs_v[2] = 1'b1; as_v[2] = 1'b1;
        reset = 1'b0;
`ifdef BUS_SLAVE_SRAM_WPROT_EN
        perr_mdl = '{default: 1'b0};
`endif
        @(posedge clk); #1;
        txn_check("reset_discard", 2, 1'b1, 32'h0000_0200, 32'h0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] pool [8];
        logic [31:0] a;
        int s, lat, stray; bit held; logic [31:0] rdata;
        for (int k = 0; k < 8; k++) pool[k] = {22'h0, 8'($urandom), 2'b00};
        for (int ss = 0; ss < NI; ss++)
            for (int k = 0; k < 8; k++) txn_check("rnd_seed", ss, 1'b0, pool[k], $urandom, 1'b0);
        for (int n = 0; n < 150; n++) begin
            s = $urandom_range(0, NI - 1);
            a = pool[$urandom_range(0, 7)] | {20'($urandom), 10'h0, 2'($urandom)};
            if (wc_of(s) > 0 && $urandom_range(0, 5) == 0) begin
                do_txn(s, 1'($urandom), a, $urandom, $urandom_range(1, wc_of(s)), 1'b0,
                       lat, rdata, stray, held);
                vectors++;
                if (lat !== -1) begin
                    miscompares++;
                    $display("[TB] FAIL rnd_abort inst%0d: rdy_ at %0d want none", s, lat);
                end
            end else begin
                txn_check("rnd", s, 1'($urandom), a, $urandom, 1'($urandom));
            end
            as_v[s] = 1'b1; cs_v[s] = 1'b1;
            @(posedge clk); #1;
        end
    endtask

`ifdef BUS_SLAVE_SRAM_WPROT_EN
    task automatic test_prot();
        int lat, stray; bit held; logic [31:0] before, after;
        do_txn(1, 1'b1, 32'h0, 32'h0, 0, 1'b0, lat, before, stray, held);
        txn_check("prot_wr0", 1, 1'b0, 32'h0, 32'h1, 1'b0);
        vectors++;
        if (perr1 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL prot_set: prot_err=%b want 1", perr1);
        end
        do_txn(1, 1'b1, 32'h0, 32'h0, 0, 1'b0, lat, after, stray, held);
        vectors++;
        if (after !== before) begin
            miscompares++;
            $display("[TB] FAIL prot_unchanged: got %h want %h", after, before);
        end
        txn_check("prot_wr40", 1, 1'b0, 32'h40, 32'h5A5A_0040, 1'b0);
        txn_check("prot_rd40", 1, 1'b1, 32'h40, 32'h0, 1'b0);
        vectors++;
        if ({perr0, perr1, perr2} !== {perr_mdl[0], perr_mdl[1], perr_mdl[2]}) begin
            miscompares++;
            $display("[TB] FAIL prot_sticky: got %b want %b", {perr0, perr1, perr2},
                     {perr_mdl[0], perr_mdl[1], perr_mdl[2]});
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        vectors++;
        if ({perr0, perr1, perr2} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL prot_clear: got %b want 000", {perr0, perr1, perr2});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_latency_sweep();
        test_abort();
        test_cs_high();
        test_back_to_back();
        test_reset_mid_wait();
        test_random();
`ifdef BUS_SLAVE_SRAM_WPROT_EN
        test_prot();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
